// File: rtl/noc_inject_arbiter_pkg.sv
// Shared constants and types for the NoC injection arbiter.
// Flit layout: {dest[12:11], ptype[10:9], payload[8:1], eop[0]}.
package noc_inject_arbiter_pkg;

    localparam int unsigned PKT_W       = 13;
    localparam int unsigned EOP_BIT     = 0;
    localparam int unsigned PAYLOAD_LSB = 1;
    localparam int unsigned PAYLOAD_W   = 8;
    localparam int unsigned TYPE_LSB    = 9;
    localparam int unsigned TYPE_W      = 2;
    localparam int unsigned DEST_LSB    = 11;
    localparam int unsigned DEST_W      = 2;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [TYPE_W-1:0]    ptype;
        logic [PAYLOAD_W-1:0] payload;
        logic                 eop;
    } packet_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Handshake bundle between the packet generators, the arbiter and the router input.
interface noc_inject_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PKT_W   = 13
);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*PKT_W-1:0] req_packet;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [PKT_W-1:0]         out_packet;
    logic                     out_ready;

    // Generator/router side of the bundle
    modport master (
        output req_valid, req_packet, out_ready,
        input  req_ready, out_valid, out_packet
    );

    // Arbiter side of the bundle
    modport slave (
        input  req_valid, req_packet, out_ready,
        output req_ready, out_valid, out_packet
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request at or above i_rr_ptr, with wrap.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_rr_ptr,
    output logic               o_found,
    output logic [IW-1:0]      o_winner
);

    int unsigned w_idx;

    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(i_rr_ptr) + k) % NUM_REQ;
            if (!o_found && i_req[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one NoC injection port among NUM_REQ generators.
// Optional stall-timeout release is enabled by defining NOC_ARB_TIMEOUT_EN.
module noc_inject_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PKT_W   = noc_inject_arbiter_pkg::PKT_W
`ifdef NOC_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    noc_inject_arbiter_if.slave        bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    import noc_inject_arbiter_pkg::*;

    localparam int unsigned IW        = $clog2(NUM_REQ);
    localparam logic [0:0]  ST_IDLE   = ARB_IDLE;
    localparam logic [0:0]  ST_LOCKED = ARB_LOCKED;

    logic [0:0]    r_state;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_rr_ptr;
    logic          r_timeout_err;

    logic             w_found;
    logic [IW-1:0]    w_winner;
    logic             w_locked;
    logic             w_sel_valid;
    logic [PKT_W-1:0] w_sel_pkt;
    logic             w_eop;
    logic             w_xfer;
    logic [IW-1:0]    w_next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req    (bus.req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    assign w_locked    = (r_state == ST_LOCKED);
    assign w_sel_valid = bus.req_valid[r_grant];
    assign w_sel_pkt   = bus.req_packet[32'(r_grant)*PKT_W +: PKT_W];
    assign w_eop       = w_sel_pkt[EOP_BIT];
    assign w_xfer      = bus.out_valid & bus.out_ready;
    assign w_next_ptr  = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    // Outputs are masked during reset so a lock being dropped never transfers a flit.
    always_comb begin
        bus.req_ready  = '0;
        bus.out_valid  = 1'b0;
        bus.out_packet = '0;
        if (w_locked && !reset) begin
            bus.out_valid          = w_sel_valid;
            bus.out_packet         = w_sel_pkt;
            bus.req_ready[r_grant] = bus.out_ready;
        end
    end

`ifdef NOC_ARB_TIMEOUT_EN
    logic [7:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state     <= ST_LOCKED;
                        r_grant     <= w_winner;
                        r_stall_cnt <= '0;
                    end
                end
                default: begin
                    if (w_xfer && w_eop) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_xfer) begin
                        r_stall_cnt <= '0;
                    end else if (!w_sel_valid) begin
                        // This stall cycle is the TIMEOUT_CYC-th one: force release.
                        if (r_stall_cnt >= 8'(TIMEOUT_CYC - 1)) begin
                            r_state       <= ST_IDLE;
                            r_rr_ptr      <= w_next_ptr;
                            r_timeout_err <= 1'b1;
                            r_stall_cnt   <= '0;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign timeout_err = r_timeout_err;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_LOCKED;
                        r_grant <= w_winner;
                    end
                end
                default: begin
                    if (w_xfer && w_eop) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
            endcase
        end
    end

    assign r_timeout_err = 1'b0;
    assign timeout_err   = r_timeout_err;
`endif

    assign grant_id = r_grant;
    assign busy     = w_locked;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_noc_inject_arbiter;

    localparam int N = 4;
    localparam int W = 13;

    logic       clk;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    noc_inject_arbiter_if #(.NUM_REQ(N), .PKT_W(W)) bus ();

    noc_inject_arbiter #(
        .NUM_REQ (N),
        .PKT_W   (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit m_locked;
    int m_grant;
    int m_ptr;
    int m_stall;
    bit m_terr;

    function automatic logic [W-1:0] mk(int dest, int ptype, int payload, bit eop);
        return {2'(dest), 2'(ptype), 8'(payload), eop};
    endfunction

    function automatic logic [W-1:0] req_pkt(int i);
        return bus.req_packet[i*W +: W];
    endfunction

    task automatic set_req(int i, bit v, logic [W-1:0] p);
        bus.req_valid[i]         = v;
        bus.req_packet[i*W +: W] = p;
    endtask

    task automatic model_adv();
        bit          found;
        bit          xfer;
        bit          terr_n;
        logic [W-1:0] p;
        int          idx;
        if (reset) begin
            m_locked = 0; m_grant = 0; m_ptr = 0; m_stall = 0; m_terr = 0;
            return;
        end
        terr_n = 0;
        if (!m_locked) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && bus.req_valid[idx]) begin
                    found = 1; m_locked = 1; m_grant = idx; m_stall = 0;
                end
            end
        end else begin
            p    = req_pkt(m_grant);
            xfer = bus.req_valid[m_grant] && bus.out_ready;
            if (xfer && p[0]) begin
                m_locked = 0;
                m_ptr    = (m_grant + 1) % N;
            end
`ifdef NOC_ARB_TIMEOUT_EN
            else if (xfer) m_stall = 0;
            else if (!bus.req_valid[m_grant]) begin
                m_stall++;
                if (m_stall >= 16) begin
                    m_locked = 0; m_ptr = (m_grant + 1) % N; terr_n = 1; m_stall = 0;
                end
            end
`endif
        end
        m_terr = terr_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_adv();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_packet = '0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b exp 0", bus.out_valid); end
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready: got %b exp 0000", bus.req_ready); end
        checks++; if (bus.out_packet !== 13'h0) begin errors++; $display("FAIL rst_out_packet: got %h exp 0", bus.out_packet); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %0b exp 0", timeout_err); end
        // Finish one packet from req1 so the pointer moves to 2, then lock req2.
        set_req(1, 1, mk(1, 1, 8'h11, 1));
        bus.out_ready = 1'b1;
        tick();
        tick();
        set_req(1, 0, '0);
        set_req(2, 1, mk(2, 0, 8'h22, 0));
        tick();
        #1;
        checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL rst_pre_lock: got busy=%0b id=%0d exp busy=1 id=2", busy, grant_id); end
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL rst_mid_no_xfer: got v=%0b rdy=%b exp v=0 rdy=0000", bus.out_valid, bus.req_ready); end
        tick();
        reset = 1'b0;
        set_req(1, 1, mk(1, 1, 8'h12, 1));
        #1;
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL rst_mid_idle: got busy=%0b v=%0b rdy=%b exp 0/0/0000", busy, bus.out_valid, bus.req_ready); end
        tick();
        #1;
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL rst_ptr_zero: got id=%0d exp 1", grant_id); end
    endtask

    task automatic test_single_pkt();
        logic [W-1:0] flits [3];
        flits[0] = mk(2, 1, 8'hAA, 0);
        flits[1] = mk(2, 1, 8'hAB, 0);
        flits[2] = mk(2, 1, 8'hAC, 1);
        do_reset();
        bus.out_ready = 1'b1;
        set_req(0, 1, flits[0]);
        #1;
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_decide: got busy=%0b v=%0b exp 0/0", busy, bus.out_valid); end
        tick();
        for (int f = 0; f < 3; f++) begin
            set_req(0, 1, flits[f]);
            #1;
            checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_grant%0d: got busy=%0b id=%0d exp 1/0", f, busy, grant_id); end
            checks++; if (bus.out_packet !== flits[f] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_flit%0d: got %h v=%0b exp %h v=1", f, bus.out_packet, bus.out_valid, flits[f]); end
            checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready%0d: got %b exp 0001", f, bus.req_ready); end
            tick();
        end
        set_req(0, 0, '0);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_release: got busy=%0b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1, mk(i, 3 - i, 8'h40 + i, 1));
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d: got busy=%0b exp 0", n, busy); end
            tick();
            #1;
            checks++; if (busy !== 1'b1 || grant_id !== 2'(n % N)) begin errors++; $display("FAIL rr_order%0d: got id=%0d busy=%0b exp id=%0d", n, grant_id, busy, n % N); end
            checks++; if (bus.out_packet !== req_pkt(n % N)) begin errors++; $display("FAIL rr_pkt%0d: got %h exp %h", n, bus.out_packet, req_pkt(n % N)); end
            tick();
        end
    endtask

    task automatic test_backpressure_wrap();
        logic [W-1:0] p1, p3;
        p1 = mk(3, 2, 8'h55, 1);
        p3 = mk(1, 3, 8'h33, 1);
        do_reset();
        set_req(1, 1, p1);
        set_req(3, 1, p3);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_packet !== p1) begin errors++; $display("FAIL bp_hold%0d: got v=%0b %h exp v=1 %h", c, bus.out_valid, bus.out_packet, p1); end
            checks++; if (bus.req_ready !== 4'b0 || grant_id !== 2'd1) begin errors++; $display("FAIL bp_noack%0d: got rdy=%b id=%0d exp 0000 id=1", c, bus.req_ready, grant_id); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready: got %b exp 0010", bus.req_ready); end
        tick();
        tick();
        #1;
        checks++; if (grant_id !== 2'd3 || bus.out_packet !== p3) begin errors++; $display("FAIL bp_next: got id=%0d %h exp id=3 %h", grant_id, bus.out_packet, p3); end
        tick();
        // Pointer wrapped to 0: req0 beats req3.
        set_req(0, 1, mk(0, 0, 8'h01, 1));
        tick();
        #1;
        checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL wrap_grant: got id=%0d busy=%0b exp id=0 busy=1", grant_id, busy); end
    endtask

    task automatic test_drop_valid();
        do_reset();
        bus.out_ready = 1'b1;
        set_req(2, 1, mk(2, 2, 8'h77, 0));
        tick();
        set_req(2, 0, mk(2, 2, 8'h77, 0));
`ifdef NOC_ARB_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got busy=%0b err=%0b exp 1/0", c, busy, timeout_err); end
            tick();
        end
        set_req(1, 1, mk(1, 0, 8'h10, 1));
        set_req(3, 1, mk(3, 0, 8'h30, 1));
        #1;
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_release: got busy=%0b err=%0b exp 0/1", busy, timeout_err); end
        tick();
        #1;
        checks++; if (timeout_err !== 1'b0 || grant_id !== 2'd3) begin errors++; $display("FAIL to_after: got err=%0b id=%0d exp 0 id=3", timeout_err, grant_id); end
`else
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (busy !== 1'b1 || timeout_err !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL drop_hold%0d: got busy=%0b err=%0b v=%0b exp 1/0/0", c, busy, timeout_err, bus.out_valid); end
            tick();
        end
        set_req(1, 1, mk(1, 0, 8'h10, 1));
        set_req(2, 1, mk(2, 2, 8'h78, 1));
        #1;
        checks++; if (grant_id !== 2'd2 || bus.req_ready !== 4'b0100) begin errors++; $display("FAIL drop_resume: got id=%0d rdy=%b exp id=2 0100", grant_id, bus.req_ready); end
        tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_release: got busy=%0b exp 0", busy); end
`endif
    endtask

    task automatic test_random();
        logic [3:0]   exp_rdy;
        logic [W-1:0] exp_pkt;
        logic         exp_v;
        logic [W-1:0] p;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 63) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                p    = W'($urandom);
                p[0] = ($urandom_range(0, 2) == 0);
                set_req(i, $urandom_range(0, 3) != 0, p);
            end
            #1;
            exp_rdy = '0;
            exp_v   = 1'b0;
            exp_pkt = '0;
            if (m_locked && !reset) begin
                exp_v            = bus.req_valid[m_grant];
                exp_pkt          = req_pkt(m_grant);
                exp_rdy[m_grant] = bus.out_ready;
            end
            checks++; if (busy !== m_locked) begin errors++; $display("FAIL rnd_busy c=%0d: got %0b exp %0b", c, busy, m_locked); end
            checks++; if (bus.out_valid !== exp_v) begin errors++; $display("FAIL rnd_valid c=%0d: got %0b exp %0b", c, bus.out_valid, exp_v); end
            checks++; if (bus.out_packet !== exp_pkt) begin errors++; $display("FAIL rnd_pkt c=%0d: got %h exp %h", c, bus.out_packet, exp_pkt); end
            checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c=%0d: got %b exp %b", c, bus.req_ready, exp_rdy); end
            checks++; if (timeout_err !== m_terr) begin errors++; $display("FAIL rnd_terr c=%0d: got %0b exp %0b", c, timeout_err, m_terr); end
            if (m_locked) begin
                checks++; if (grant_id !== 2'(m_grant)) begin errors++; $display("FAIL rnd_grant c=%0d: got %0d exp %0d", c, grant_id, m_grant); end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_pkt();
        test_round_robin();
        test_backpressure_wrap();
        test_drop_valid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
